// File: rtl/lc3b_types.sv
// Shared LC-3b/LC-3X type definitions: ALU opcode enum, machine word and
// the sequential ALU control states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // Encodings 16..31 are deliberately left undefined so bad_op can be exercised.
    typedef enum logic [4:0] {
        alu_add   = 5'd0,
        alu_sub   = 5'd1,
        alu_and   = 5'd2,
        alu_or    = 5'd3,
        alu_xor   = 5'd4,
        alu_xnor  = 5'd5,
        alu_nor   = 5'd6,
        alu_nand  = 5'd7,
        alu_not   = 5'd8,
        alu_passa = 5'd9,
        alu_passb = 5'd10,
        alu_sll   = 5'd11,
        alu_srl   = 5'd12,
        alu_sra   = 5'd13,
        alu_mult  = 5'd14,
        alu_div   = 5'd15
    } lc3b_aluop;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} lc3x_alu_state_t;

endpackage

// File: rtl/lc3x_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add, LSB first) and restoring divider
// (MSB first); one step per cycle for WIDTH cycles after i_start.
module lc3x_muldiv_iter
    import lc3b_types::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    logic             r_busy;
    logic             r_is_div;
    logic [SHW:0]     r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;

    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_acc_nxt = r_acc + (r_opb[0] ? r_opa : '0);

    // Restoring step: a clear borrow bit means the shifted remainder covers the divisor.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_opb};
    assign w_ge      = ~w_trial[WIDTH];
    assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    assign o_done   = r_busy & (r_cnt == CNT_LAST);
    assign o_result = r_is_div ? w_quo_nxt : w_acc_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_is_div <= i_is_div;
            r_cnt    <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_done) r_busy <= 1'b0;
        end
    end

    // Datapath registers carry no reset; r_busy gates every use of them.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_acc <= '0;
            r_opa <= i_a;
            r_opb <= i_b;
            r_rem <= '0;
            r_quo <= i_a;
        end else if (r_busy) begin
            if (r_is_div) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
            end else begin
                r_acc <= w_acc_nxt;
                r_opa <= r_opa << 1;
                r_opb <= r_opb >> 1;
            end
        end
    end

endmodule

// File: rtl/lc3x_seq_alu.sv
// LC-3X execute-stage ALU with valid/ready handshakes: single-cycle ops
// finish in one cycle, mult/div iterate WIDTH cycles in lc3x_muldiv_iter.
module lc3x_seq_alu
    import lc3b_types::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  lc3b_aluop        aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             div_zero,
    output logic             bad_op
);

    lc3x_alu_state_t  r_state;
    logic [WIDTH-1:0] r_f;
    logic             r_div_zero;
    logic             r_bad_op;

    logic                    w_accept;
    logic                    w_start;
    logic                    w_b_zero;
    logic                    w_md_done;
    logic [WIDTH-1:0]        w_md_result;
    logic [WIDTH-1:0]        w_f1;
    logic                    w_bad;
    logic signed [WIDTH-1:0] w_a_s;
    logic [SHW-1:0]          w_sh;

    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_b_zero  = (b == '0);
    assign w_start   = w_accept & ((aluop == alu_mult) | ((aluop == alu_div) & ~w_b_zero));
    assign out_valid = (r_state == DONE);
    assign f         = r_f;
    assign div_zero  = r_div_zero;
    assign bad_op    = r_bad_op;

    assign w_a_s = a;
    assign w_sh  = b[SHW-1:0];

    always_comb begin
        w_f1  = '0;
        w_bad = 1'b0;
        case (aluop)
            alu_add:   w_f1 = a + b;
            alu_sub:   w_f1 = a - b;
            alu_and:   w_f1 = a & b;
            alu_or:    w_f1 = a | b;
            alu_xor:   w_f1 = a ^ b;
            alu_xnor:  w_f1 = ~(a ^ b);
            alu_nor:   w_f1 = ~(a | b);
            alu_nand:  w_f1 = ~(a & b);
            alu_not:   w_f1 = ~a;
            alu_passa: w_f1 = a;
            alu_passb: w_f1 = b;
            alu_sll:   w_f1 = a << w_sh;
            alu_srl:   w_f1 = a >> w_sh;
            alu_sra:   w_f1 = w_a_s >>> w_sh;
            alu_mult,
            alu_div:   w_f1 = '0;
            default:   w_bad = 1'b1;
        endcase
    end

    lc3x_muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_start  (w_start),
        .i_is_div (aluop == alu_div),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    // An accept always wins, which gives back-to-back issue from DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_f        <= '0;
            r_div_zero <= 1'b0;
            r_bad_op   <= 1'b0;
        end else if (w_accept) begin
            r_div_zero <= 1'b0;
            r_bad_op   <= 1'b0;
            if (aluop == alu_mult) begin
                r_state <= MUL;
            end else if (aluop == alu_div) begin
                if (w_b_zero) begin
                    r_state    <= DONE;
                    r_f        <= '1;
                    r_div_zero <= 1'b1;
                end else begin
                    r_state <= DIV;
                end
            end else begin
                r_state  <= DONE;
                r_f      <= w_f1;
                r_bad_op <= w_bad;
            end
        end else begin
            case (r_state)
                MUL, DIV: begin
                    if (w_md_done) begin
                        r_state <= DONE;
                        r_f     <= w_md_result;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3x_seq_alu.sv
// Directed and randomized checks of lc3x_seq_alu against an arithmetic reference model.
module tb_lc3x_seq_alu;
    import lc3b_types::*;

    localparam int W = 16;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    lc3b_aluop    aluop     = alu_add;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] f;
    logic         div_zero;
    logic         bad_op;

    int n_checks = 0;
    int n_errors = 0;

    lc3x_seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .div_zero  (div_zero),
        .bad_op    (bad_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input lc3b_aluop op, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic dz, output logic bad);
        longint unsigned ux = x;
        longint unsigned uy = y;
        int sh = int'(y % 16);
        dz  = 1'b0;
        bad = 1'b0;
        r   = '0;
        case (op)
            alu_add:   r = W'(ux + uy);
            alu_sub:   r = W'(ux + 65536 - uy);
            alu_and:   r = x & y;
            alu_or:    r = x | y;
            alu_xor:   r = x ^ y;
            alu_xnor:  r = ~(x ^ y);
            alu_nor:   r = ~(x | y);
            alu_nand:  r = ~(x & y);
            alu_not:   r = ~x;
            alu_passa: r = x;
            alu_passb: r = y;
            alu_sll:   r = W'(ux * (64'd1 << sh));
            alu_srl:   r = W'(ux / (64'd1 << sh));
            alu_sra:   r = W'(int'($signed(x)) >>> sh);
            alu_mult:  r = W'(ux * uy);
            alu_div: begin
                if (y == 0) begin
                    r  = '1;
                    dz = 1'b1;
                end else begin
                    r = W'(ux / uy);
                end
            end
            default:   bad = 1'b1;
        endcase
    endfunction

    task automatic run_op(input string name, input lc3b_aluop op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] ef;
        logic         edz, ebad, busy_bad;
        int           lat, elat;
        model(op, x, y, ef, edz, ebad);
        elat = (op == alu_mult || (op == alu_div && y != 0)) ? W + 1 : 1;
        @(negedge clk);
        in_valid = 1'b1; aluop = op; a = x; b = y; out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        lat = 1; busy_bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0) busy_bad = 1'b1;
            in_valid = 1'b1;
            aluop = lc3b_aluop'(5'($urandom));
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, W'(lat), W'(elat));
        check({name, "_f"}, f, ef);
        check({name, "_div_zero"}, W'(div_zero), W'(edz));
        check({name, "_bad_op"}, W'(bad_op), W'(ebad));
        check({name, "_busy_blocks"}, W'(busy_bad), W'(0));
    endtask

    initial begin
        logic [W-1:0] ef, held;
        logic         edz, ebad;
        int           seen;

        // Reset state
        #12;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_f", f, W'(0));
        check("rst_flags", W'({div_zero, bad_op}), W'(0));
        @(negedge clk); reset_n = 1'b1;

        run_op("add_ovf", alu_add, 16'h7FFF, 16'h0001);
        run_op("sra", alu_sra, 16'h8004, 16'h0012);
        run_op("sll_sh0", alu_sll, 16'h0001, 16'h0010);
        run_op("mult", alu_mult, 16'h0123, 16'h0010);
        run_op("mult_max", alu_mult, 16'hFFFF, 16'hFFFF);
        run_op("div", alu_div, 16'h0064, 16'h0007);
        run_op("div_zero", alu_div, 16'h1234, 16'h0000);
        run_op("bad_op", lc3b_aluop'(5'd20), 16'h5555, 16'hAAAA);
        run_op("xnor", alu_xnor, 16'h0F0F, 16'h00FF);

        // Back-pressure: result held while out_ready=0, then zero-bubble issue
        @(negedge clk);
        in_valid = 1'b1; aluop = alu_add; a = 16'h1111; b = 16'h2222; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; aluop = alu_sub; a = 16'h0005; b = 16'h0007;
        check("bp_f0", f, 16'h3333);
        held = f;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_f", f, held);
            check("bp_hold_valid", W'(out_valid), W'(1));
            check("bp_hold_in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1; #1;
        check("bp_release_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_valid", W'(out_valid), W'(1));
        check("bp_next_f", f, 16'hFFFE);

        // Randomized mix against the reference model
        for (int i = 0; i < 40; i++) begin
            int r;
            lc3b_aluop op;
            logic [W-1:0] x, y;
            r  = int'($urandom_range(0, 19));
            op = (r < 16) ? lc3b_aluop'(5'(r)) : lc3b_aluop'(5'(r + 8));
            x  = W'($urandom);
            y  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            if (op == alu_div && y != 0 && $urandom_range(0, 1) == 1) y = W'($urandom_range(1, 300));
            run_op("rand", op, x, y);
        end

        // Reset asserted mid-division
        @(negedge clk);
        in_valid = 1'b1; aluop = alu_div; a = 16'h1234; b = 16'h0005;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_f", f, W'(0));
        check("midrst_flags", W'({div_zero, bad_op}), W'(0));
        @(negedge clk); reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", W'(seen), W'(0));

        model(alu_nand, 16'hF0F0, 16'hFF00, ef, edz, ebad);
        run_op("post_rst_nand", alu_nand, 16'hF0F0, 16'hFF00);
        check("post_rst_model", f, ef);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
